// File: rtl/check_node_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | check_node_unit : min-sum LDPC check node, degree 8 over 4 two-lane beats  |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module check_node_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] data_in_e,
  input  logic [15:0] data_in_o,
  output logic [15:0] data_out_e,
  output logic [15:0] data_out_o,
  output logic        we,
  output logic        done
);

  localparam logic [14:0] C_MAG_MAX = 15'h7fff;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  beat_cnt_q, beat_cnt_d;
  logic [1:0]  out_cnt_q, out_cnt_d;
  logic [14:0] min1_q, min1_d;
  logic [14:0] min2_q, min2_d;
  logic [2:0]  idx1_q, idx1_d;
  logic        sgn_q, sgn_d;
  logic [7:0]  signs_q, signs_d;
  logic        done_q, done_d;

  logic        w_accept;
  logic        w_row_start;
  logic [14:0] w_mag_e, w_mag_o;
  logic [14:0] w_f1, w_f2;
  logic [2:0]  w_fi;
  logic [7:0]  w_fsigns;
  logic [2:0]  w_idx_e, w_idx_o;
  logic [2:0]  w_oidx_e, w_oidx_o;

  // 16'h8000 has no positive counterpart, so it saturates to the largest magnitude
  function automatic logic [14:0] mag_of(input logic [15:0] x);
    logic [15:0] neg;
    neg = 16'd0 - x;
    if (x == 16'h8000)
      return C_MAG_MAX;
    else if (x[15])
      return neg[14:0];
    else
      return x[14:0];
  endfunction

  function automatic logic [15:0] msg_of(input logic [14:0] mag, input logic neg);
    return neg ? (16'd0 - {1'b0, mag}) : {1'b0, mag};
  endfunction

  assign w_accept    = in_valid && in_ready;
  assign w_row_start = (state_q == IDLE);
  assign w_idx_e     = {beat_cnt_q, 1'b0};
  assign w_idx_o     = {beat_cnt_q, 1'b1};

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    out_cnt_d  = out_cnt_q;
    min1_d     = min1_q;
    min2_d     = min2_q;
    idx1_d     = idx1_q;
    sgn_d      = sgn_q;
    signs_d    = signs_q;
    done_d     = 1'b0;

    w_mag_e  = mag_of(data_in_e);
    w_mag_o  = mag_of(data_in_o);
    w_f1     = w_row_start ? C_MAG_MAX : min1_q;
    w_f2     = w_row_start ? C_MAG_MAX : min2_q;
    w_fi     = w_row_start ? 3'd0 : idx1_q;
    w_fsigns = w_row_start ? 8'd0 : signs_q;

    // Even lane folds first so it keeps idx1 on an equal magnitude
    if (w_mag_e < w_f1) begin
      w_f2 = w_f1;
      w_f1 = w_mag_e;
      w_fi = w_idx_e;
    end else if (w_mag_e <= w_f2) begin
      w_f2 = w_mag_e;
    end
    if (w_mag_o < w_f1) begin
      w_f2 = w_f1;
      w_f1 = w_mag_o;
      w_fi = w_idx_o;
    end else if (w_mag_o <= w_f2) begin
      w_f2 = w_mag_o;
    end
    w_fsigns[w_idx_e] = data_in_e[15];
    w_fsigns[w_idx_o] = data_in_o[15];

    if (w_accept) begin
      min1_d  = w_f1;
      min2_d  = w_f2;
      idx1_d  = w_fi;
      signs_d = w_fsigns;
      sgn_d   = (w_row_start ? 1'b0 : sgn_q) ^ data_in_e[15] ^ data_in_o[15];
    end

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          state_d    = COLLECT;
          beat_cnt_d = 2'd1;
        end
      end
      COLLECT: begin
        if (w_accept) begin
          if (beat_cnt_q == 2'd3) begin
            state_d    = EMIT;
            beat_cnt_d = 2'd0;
            out_cnt_d  = 2'd0;
          end else begin
            beat_cnt_d = beat_cnt_q + 2'd1;
          end
        end
      end
      EMIT: begin
        out_cnt_d = out_cnt_q + 2'd1;
        if (out_cnt_q == 2'd3) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= 2'd0;
      out_cnt_q  <= 2'd0;
      min1_q     <= C_MAG_MAX;
      min2_q     <= C_MAG_MAX;
      idx1_q     <= 3'd0;
      sgn_q      <= 1'b0;
      signs_q    <= 8'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      out_cnt_q  <= out_cnt_d;
      min1_q     <= min1_d;
      min2_q     <= min2_d;
      idx1_q     <= idx1_d;
      sgn_q      <= sgn_d;
      signs_q    <= signs_d;
      done_q     <= done_d;
    end
  end

  assign w_oidx_e = {out_cnt_q, 1'b0};
  assign w_oidx_o = {out_cnt_q, 1'b1};

  assign in_ready   = rst && (state_q != EMIT);
  assign we         = (state_q == EMIT);
  assign done       = done_q;
  assign data_out_e = we ? msg_of((w_oidx_e == idx1_q) ? min2_q : min1_q,
                                  sgn_q ^ signs_q[w_oidx_e]) : 16'd0;
  assign data_out_o = we ? msg_of((w_oidx_o == idx1_q) ? min2_q : min1_q,
                                  sgn_q ^ signs_q[w_oidx_o]) : 16'd0;

endmodule
`default_nettype wire

// File: tb/tb_check_node_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_check_node_unit : directed table-driven bench for check_node_unit       |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_check_node_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in_e;
  logic [15:0] data_in_o;
  logic [15:0] data_out_e;
  logic [15:0] data_out_o;
  logic        we;
  logic        done;

  int total;
  int bad;

  check_node_unit dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in_e  (data_in_e),
    .data_in_o  (data_in_o),
    .data_out_e (data_out_e),
    .data_out_o (data_out_o),
    .we         (we),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][15:0] in_e;
    logic [3:0][15:0] in_o;
    logic [3:0][15:0] exp_e;
    logic [3:0][15:0] exp_o;
    int               gap;
  } vec_t;

  vec_t tbl[7];

  function automatic vec_t mk(input int i0, input int i1, input int i2, input int i3,
                              input int i4, input int i5, input int i6, input int i7,
                              input int x0, input int x1, input int x2, input int x3,
                              input int x4, input int x5, input int x6, input int x7,
                              input int gap);
    vec_t v;
    v.in_e[0] = i0[15:0]; v.in_o[0] = i1[15:0];
    v.in_e[1] = i2[15:0]; v.in_o[1] = i3[15:0];
    v.in_e[2] = i4[15:0]; v.in_o[2] = i5[15:0];
    v.in_e[3] = i6[15:0]; v.in_o[3] = i7[15:0];
    v.exp_e[0] = x0[15:0]; v.exp_o[0] = x1[15:0];
    v.exp_e[1] = x2[15:0]; v.exp_o[1] = x3[15:0];
    v.exp_e[2] = x4[15:0]; v.exp_o[2] = x5[15:0];
    v.exp_e[3] = x6[15:0]; v.exp_o[3] = x7[15:0];
    v.gap = gap;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Starts and ends on a falling edge; the final edge is where the first output beat is due
  task automatic send_beats(input vec_t v);
    for (int k = 0; k < 4; k++) begin
      int guard;
      in_valid  = 1'b1;
      data_in_e = v.in_e[k];
      data_in_o = v.in_o[k];
      guard = 0;
      while (!in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        total++;
        bad++;
        $display("FAIL ready_timeout: actual=0 required=1 at %0t", $time);
      end
      @(posedge clk);
      @(negedge clk);
      if (k < 3 && v.gap > 0) begin
        in_valid = 1'b0;
        repeat (v.gap - 1) @(negedge clk);
        chk("out_zero_gap", data_out_e | data_out_o, 16'd0);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_emit(input vec_t v);
    for (int c = 0; c < 4; c++) begin
      chk("we_high", {15'd0, we}, 16'd1);
      chk("ready_low_emit", {15'd0, in_ready}, 16'd0);
      chk("out_e", data_out_e, v.exp_e[c]);
      chk("out_o", data_out_o, v.exp_o[c]);
      @(negedge clk);
    end
    chk("done_pulse", {15'd0, done}, 16'd1);
    chk("we_low_done", {15'd0, we}, 16'd0);
    chk("ready_back", {15'd0, in_ready}, 16'd1);
    chk("out_zero_done", data_out_e | data_out_o, 16'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    data_in_e = 16'd0;
    data_in_o = 16'd0;

    tbl[0] = mk(5, -3, 7, 10, -2, 8, 9, 6,   2, -2, 2, 2, -3, 2, 2, 2,   0);
    tbl[1] = mk(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768,
                -32767, -32767, -32767, -32767, -32767, -32767, -32767, -32767, 0);
    tbl[2] = mk(4, 4, 4, 4, 4, 4, 4, 4,   4, 4, 4, 4, 4, 4, 4, 4,   0);
    tbl[3] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0,   0);
    tbl[4] = mk(5, -3, 7, 10, -2, 8, 9, 6,   2, -2, 2, 2, -3, 2, 2, 2,   3);
    tbl[5] = mk(3, -7, 1, 1, -5, 9, 2, -4,   -1, 1, -1, -1, 1, -1, -1, 1,   1);
    tbl[6] = mk(100, 20, 30, -40, 50, 60, 70, 25,   -20, -25, -20, 20, -20, -20, -20, -20,   0);

    repeat (2) @(negedge clk);
    chk("rst_ready", {15'd0, in_ready}, 16'd0);
    chk("rst_we", {15'd0, we}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_out", data_out_e | data_out_o, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {15'd0, in_ready}, 16'd1);

    for (int r = 0; r < 7; r++) begin
      send_beats(tbl[r]);
      check_emit(tbl[r]);
      @(negedge clk);
      chk("done_single", {15'd0, done}, 16'd0);
    end

    // Back-to-back: row 2 beat 0 held valid through EMIT of row 1
    send_beats(tbl[1]);
    in_valid  = 1'b1;
    data_in_e = tbl[0].in_e[0];
    data_in_o = tbl[0].in_o[0];
    check_emit(tbl[1]);
    send_beats(tbl[0]);
    check_emit(tbl[0]);
    @(negedge clk);

    // Reset after the second output beat
    send_beats(tbl[0]);
    chk("abort_we0", data_out_e, tbl[0].exp_e[0]);
    @(negedge clk);
    chk("abort_we1", data_out_e, tbl[0].exp_e[1]);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_we_low", {15'd0, we}, 16'd0);
    chk("abort_ready_low", {15'd0, in_ready}, 16'd0);
    chk("abort_out_zero", data_out_e | data_out_o, 16'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_done", {15'd0, done | we}, 16'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready_back", {15'd0, in_ready}, 16'd1);
    chk("abort_still_no_done", {15'd0, done | we}, 16'd0);
    send_beats(tbl[0]);
    check_emit(tbl[0]);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
